// File: rtl/l2_flush_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : l2_flush_seq_pkg
//  Description : Shared types for the Spandex L2 flush/invalidate walker:
//                walker state encoding and line-state bit positions used to
//                interpret the tag/state array lookup response.
//  Revision    : 1.0  initial release
// ============================================================================
package l2_flush_seq_pkg;

    // Walker states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RD    = 3'd2,
        ST_WAIT  = 3'd3,
        ST_EVICT = 3'd4,
        ST_INVAL = 3'd5,
        ST_ADV   = 3'd6,
        ST_DRAIN = 3'd7
    } l2_flush_state_t;

    // Bit positions inside a packed line-state word {dirty, valid}
    localparam int c_line_vld_bit   = 0;
    localparam int c_line_dirty_bit = 1;
    localparam int c_line_state_w   = 2;

    // A line needs a writeback only when it is both valid and dirty
    function automatic logic line_needs_wb(input logic [c_line_state_w-1:0] line);
        return line[c_line_vld_bit] & line[c_line_dirty_bit];
    endfunction

endpackage : l2_flush_seq_pkg
`default_nettype wire

// File: rtl/l2_flush_seq.sv
`default_nettype none
// ============================================================================
//  Module      : l2_flush_seq
//  Description : Flush/invalidate walker for the Spandex L2. Walks every
//                (set, way), writes back dirty lines through the eviction
//                path and optionally invalidates valid lines. The set/way/
//                ongoing counters live in the L2 status-register block; this
//                block only reads them back and emits one-cycle set/clr/incr
//                pulses.
//  Ports       : clk, rst (async, active-high)
//                flush_req_*      : flush request handshake (+inval option)
//                flush_hold       : stall for new line reads
//                flush_set/way    : counter read-back, mshr_cnt free MSHRs
//                *_ongoing_flush, *_flush_set, *_flush_way : register pulses
//                rd_req_*/rd_rsp_*: tag/state array lookup
//                evict_*          : writeback request (valid/ready)
//                inv_wr_en        : invalidate write at rd_set/rd_way
//                flush_done       : completion pulse
//  Revision    : 1.0  initial release
// ============================================================================
module l2_flush_seq
    import l2_flush_seq_pkg::*;
#(
    parameter int L2_SETS  = 256,
    parameter int L2_WAYS  = 8,
    parameter int SET_BITS = 8,
    parameter int WAY_BITS = 3,
    parameter int N_MSHR   = 4,
    parameter int MSHR_BP1 = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_req_valid,
    input  logic                flush_req_inval,
    output logic                flush_req_ready,
    input  logic                flush_hold,
    input  logic [SET_BITS:0]   flush_set,
    input  logic [WAY_BITS:0]   flush_way,
    input  logic [MSHR_BP1-1:0] mshr_cnt,
    output logic                set_ongoing_flush,
    output logic                clr_ongoing_flush,
    output logic                incr_flush_set,
    output logic                clr_flush_set,
    output logic                incr_flush_way,
    output logic                clr_flush_way,
    output logic                rd_req_valid,
    output logic [SET_BITS-1:0] rd_set,
    output logic [WAY_BITS-1:0] rd_way,
    input  logic                rd_rsp_valid,
    input  logic                rd_rsp_vld,
    input  logic                rd_rsp_dirty,
    output logic                evict_valid,
    input  logic                evict_ready,
    output logic [SET_BITS-1:0] evict_set,
    output logic [WAY_BITS-1:0] evict_way,
    output logic                inv_wr_en,
    output logic                flush_done
);

    localparam logic [SET_BITS:0]   c_last_set  = (SET_BITS+1)'(L2_SETS - 1);
    localparam logic [WAY_BITS:0]   c_last_way  = (WAY_BITS+1)'(L2_WAYS - 1);
    localparam logic [MSHR_BP1-1:0] c_mshr_full = MSHR_BP1'(N_MSHR);

    l2_flush_state_t            r_state;
    l2_flush_state_t            w_next;
    logic                       r_inval;
    logic                       r_evict_held;
    logic [SET_BITS-1:0]        r_evict_set;
    logic [WAY_BITS-1:0]        r_evict_way;
    logic [c_line_state_w-1:0]  w_rsp_line;

    always_comb begin
        w_rsp_line                   = '0;
        w_rsp_line[c_line_vld_bit]   = rd_rsp_vld;
        w_rsp_line[c_line_dirty_bit] = rd_rsp_dirty;
    end

    // Lookup index is simply the low bits of the register-block counters;
    // the MSB only exists so the final increment can run past the last set.
    assign rd_set    = flush_set[SET_BITS-1:0];
    assign rd_way    = flush_way[WAY_BITS-1:0];
    assign evict_set = r_evict_set;
    assign evict_way = r_evict_way;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_inval      <= 1'b0;
            r_evict_held <= 1'b0;
            r_evict_set  <= '0;
            r_evict_way  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && flush_req_valid) begin
                r_inval <= flush_req_inval;
            end
            // Capture the lookup index so the eviction address is stable
            // for the whole handshake regardless of counter activity.
            if (r_state == ST_RD && !flush_hold) begin
                r_evict_set <= flush_set[SET_BITS-1:0];
                r_evict_way <= flush_way[WAY_BITS-1:0];
            end
            // Once offered, the eviction stays valid even if MSHRs vanish.
            r_evict_held <= (r_state == ST_EVICT) && evict_valid && !evict_ready;
        end
    end

    always_comb begin
        w_next            = r_state;
        flush_req_ready   = 1'b0;
        set_ongoing_flush = 1'b0;
        clr_ongoing_flush = 1'b0;
        incr_flush_set    = 1'b0;
        clr_flush_set     = 1'b0;
        incr_flush_way    = 1'b0;
        clr_flush_way     = 1'b0;
        rd_req_valid      = 1'b0;
        evict_valid       = 1'b0;
        inv_wr_en         = 1'b0;
        flush_done        = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                flush_req_ready = 1'b1;
                if (flush_req_valid) begin
                    set_ongoing_flush = 1'b1;
                    clr_flush_set     = 1'b1;
                    clr_flush_way     = 1'b1;
                    w_next            = ST_START;
                end
            end
            // Counters were cleared at the previous edge; give them a cycle
            // before the first lookup samples them.
            ST_START: w_next = ST_RD;
            ST_RD: begin
                if (!flush_hold) begin
                    rd_req_valid = 1'b1;
                    w_next       = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rd_rsp_valid) begin
                    if (line_needs_wb(w_rsp_line)) begin
                        w_next = ST_EVICT;
                    end else if (w_rsp_line[c_line_vld_bit] && r_inval) begin
                        w_next = ST_INVAL;
                    end else begin
                        w_next = ST_ADV;
                    end
                end
            end
            ST_EVICT: begin
                evict_valid = r_evict_held || (mshr_cnt != '0);
                if (evict_valid && evict_ready) begin
                    w_next = r_inval ? ST_INVAL : ST_ADV;
                end
            end
            ST_INVAL: begin
                inv_wr_en = 1'b1;
                w_next    = ST_ADV;
            end
            ST_ADV: begin
                if (flush_way == c_last_way) begin
                    clr_flush_way  = 1'b1;
                    incr_flush_set = 1'b1;
                    w_next         = (flush_set == c_last_set) ? ST_DRAIN : ST_RD;
                end else begin
                    incr_flush_way = 1'b1;
                    w_next         = ST_RD;
                end
            end
            ST_DRAIN: begin
                if (mshr_cnt == c_mshr_full) begin
                    clr_ongoing_flush = 1'b1;
                    clr_flush_set     = 1'b1;
                    flush_done        = 1'b1;
                    w_next            = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule : l2_flush_seq
`default_nettype wire

// File: tb/tb_l2_flush_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l2_flush_seq
//  Description : Self-checking bench for l2_flush_seq on a 2-set x 2-way L2.
//                Emulates the status-register block, tag/state array and
//                MSHR pool; an event-queue model predicts the walk order.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_l2_flush_seq;

    localparam int L2_SETS  = 2;
    localparam int L2_WAYS  = 2;
    localparam int SET_BITS = 1;
    localparam int WAY_BITS = 1;
    localparam int N_MSHR   = 4;
    localparam int MSHR_BP1 = 3;

    localparam logic [1:0] K_RD = 2'd0, K_EV = 2'd1, K_INV = 2'd2, K_DONE = 2'd3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                flush_req_valid = 1'b0, flush_req_inval = 1'b0, flush_req_ready;
    logic                flush_hold = 1'b0;
    logic [SET_BITS:0]   flush_set;
    logic [WAY_BITS:0]   flush_way;
    logic [MSHR_BP1-1:0] mshr_cnt;
    logic set_ongoing_flush, clr_ongoing_flush, incr_flush_set, clr_flush_set;
    logic incr_flush_way, clr_flush_way, rd_req_valid, evict_valid, inv_wr_en, flush_done;
    logic [SET_BITS-1:0] rd_set, evict_set;
    logic [WAY_BITS-1:0] rd_way, evict_way;
    logic                rd_rsp_valid = 1'b0, rd_rsp_vld = 1'b0, rd_rsp_dirty = 1'b0;
    logic                evict_ready = 1'b0;

    always #5 clk = ~clk;

    l2_flush_seq #(
        .L2_SETS(L2_SETS), .L2_WAYS(L2_WAYS), .SET_BITS(SET_BITS),
        .WAY_BITS(WAY_BITS), .N_MSHR(N_MSHR), .MSHR_BP1(MSHR_BP1)
    ) dut (
        .clk(clk), .rst(rst),
        .flush_req_valid(flush_req_valid), .flush_req_inval(flush_req_inval),
        .flush_req_ready(flush_req_ready), .flush_hold(flush_hold),
        .flush_set(flush_set), .flush_way(flush_way), .mshr_cnt(mshr_cnt),
        .set_ongoing_flush(set_ongoing_flush), .clr_ongoing_flush(clr_ongoing_flush),
        .incr_flush_set(incr_flush_set), .clr_flush_set(clr_flush_set),
        .incr_flush_way(incr_flush_way), .clr_flush_way(clr_flush_way),
        .rd_req_valid(rd_req_valid), .rd_set(rd_set), .rd_way(rd_way),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_vld(rd_rsp_vld), .rd_rsp_dirty(rd_rsp_dirty),
        .evict_valid(evict_valid), .evict_ready(evict_ready),
        .evict_set(evict_set), .evict_way(evict_way),
        .inv_wr_en(inv_wr_en), .flush_done(flush_done)
    );

    // ---------------- environment models ----------------
    logic                mshr_force_en = 1'b0;
    logic [MSHR_BP1-1:0] mshr_force    = '0;
    logic                ret_en        = 1'b1;

    // Status-register block counters
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_set <= '0;
            flush_way <= '0;
        end else begin
            if (clr_flush_set)       flush_set <= '0;
            else if (incr_flush_set) flush_set <= flush_set + 1'b1;
            if (clr_flush_way)       flush_way <= '0;
            else if (incr_flush_way) flush_way <= flush_way + 1'b1;
        end
    end

    // MSHR pool: an eviction takes one entry, entries return at random
    always @(posedge clk or posedge rst) begin
        if (rst) mshr_cnt <= MSHR_BP1'(N_MSHR);
        else if (mshr_force_en) mshr_cnt <= mshr_force;
        else mshr_cnt <= mshr_cnt
                         - MSHR_BP1'(evict_valid && evict_ready && mshr_cnt != '0)
                         + MSHR_BP1'(ret_en && (mshr_cnt < MSHR_BP1'(N_MSHR)) && ($urandom_range(0, 2) == 0));
    end

    logic mem_vld   [L2_SETS][L2_WAYS];
    logic mem_dirty [L2_SETS][L2_WAYS];

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [1:0]          kind;
        logic [SET_BITS-1:0] s;
        logic [WAY_BITS-1:0] w;
    } ev_t;
    ev_t expq[$];

    int checks = 0, errors = 0;
    int cyc = 0;
    bit busy = 0;
    int n_rd, n_fire, n_inv, n_done, n_clr_ong, n_set_ong, n_ev_high, n_ev_m0, n_rd_hold;
    int first_rd_cyc, done_cyc, last_adv_cyc, ev_run;
    bit last_adv_seen;
    logic [1:0] last_fire;
    logic [1:0] rd_log[$];

    logic s_rd_req = 0, s_ev_valid = 0, s_ev_ready = 0;
    logic [SET_BITS-1:0] s_rd_set = '0, s_ev_set = '0;
    logic [WAY_BITS-1:0] s_rd_way = '0, s_ev_way = '0;

    // stimulus knobs
    int  ready_mode = 1;   // 0 random, 1 always, 2 after 4 waiting cycles
    bit  hold_force = 0, hold_val = 0, hold_rand = 0;
    bit  spur_en = 0, req_rand = 0;
    int  rsp_lat_max = 0;
    bit  pend = 0;
    int  pend_cnt = 0;
    logic [SET_BITS-1:0] pend_set = '0;
    logic [WAY_BITS-1:0] pend_way = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic pop_check(input string nm, input logic [1:0] k,
                             input logic [SET_BITS-1:0] s, input logic [WAY_BITS-1:0] w);
        ev_t e;
        ev_t got;
        chk({nm, "_expected"}, 32'(expq.size() != 0), 32'd1);
        if (expq.size() != 0) begin
            e   = expq.pop_front();
            got = '{kind: k, s: s, w: w};
            chk(nm, 32'(got), 32'(e));
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", 32'(flush_req_ready), 32'd1);
            chk("rst_outs", 32'({set_ongoing_flush, clr_ongoing_flush, incr_flush_set, clr_flush_set,
                                incr_flush_way, clr_flush_way, rd_req_valid, evict_valid,
                                inv_wr_en, flush_done}), 32'd0);
            busy = 0;
            expq.delete();
            s_rd_req = 0; s_ev_valid = 0; s_ev_ready = 0; ev_run = 0;
        end else begin
            cyc++;
            chk("ready", 32'(flush_req_ready), 32'(!busy));
            chk("set_ongoing", 32'(set_ongoing_flush), 32'(!busy && flush_req_valid));
            chk("clr_ongoing", 32'(clr_ongoing_flush), 32'(flush_done));
            chk("clr_set", 32'(clr_flush_set), 32'((!busy && flush_req_valid) || flush_done));
            chk("ovl_set", 32'(incr_flush_set && clr_flush_set), 32'd0);
            chk("ovl_way", 32'(incr_flush_way && clr_flush_way), 32'd0);
            chk("rd_under_hold", 32'(rd_req_valid && flush_hold), 32'd0);
            if (s_ev_valid && !s_ev_ready)
                chk("evict_hold", 32'({evict_valid, evict_set, evict_way}), 32'({1'b1, s_ev_set, s_ev_way}));
            else if (evict_valid)
                chk("evict_needs_mshr", 32'(mshr_cnt != '0), 32'd1);

            // A new request is accepted only when the walker is idle
            if (!busy && flush_req_valid) begin
                busy = 1;
                for (int s = 0; s < L2_SETS; s++)
                    for (int w = 0; w < L2_WAYS; w++) begin
                        expq.push_back('{kind: K_RD, s: SET_BITS'(s), w: WAY_BITS'(w)});
                        if (mem_vld[s][w] && mem_dirty[s][w])
                            expq.push_back('{kind: K_EV, s: SET_BITS'(s), w: WAY_BITS'(w)});
                        if (mem_vld[s][w] && flush_req_inval)
                            expq.push_back('{kind: K_INV, s: SET_BITS'(s), w: WAY_BITS'(w)});
                    end
                expq.push_back('{kind: K_DONE, s: '0, w: '0});
            end
            if (rd_req_valid) pop_check("rd", K_RD, rd_set, rd_way);
            if (evict_valid && evict_ready) pop_check("evict", K_EV, evict_set, evict_way);
            if (inv_wr_en) pop_check("inval", K_INV, rd_set, rd_way);
            if (flush_done) begin
                chk("done_mshr_full", 32'(mshr_cnt), N_MSHR);
                pop_check("done", K_DONE, '0, '0);
                chk("done_queue_empty", 32'(expq.size()), 32'd0);
                busy = 0;
            end

            // statistics for directed expectations
            if (rd_req_valid) begin
                n_rd++;
                if (rd_log.size() < 8) rd_log.push_back({rd_set, rd_way});
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                if (flush_hold) n_rd_hold++;
            end
            if (evict_valid && evict_ready) begin n_fire++; last_fire = {evict_set, evict_way}; end
            if (evict_valid) n_ev_high++;
            if (evict_valid && mshr_cnt == '0 && !s_ev_valid) n_ev_m0++;
            if (inv_wr_en) n_inv++;
            if (flush_done) begin n_done++; done_cyc = cyc; end
            if (clr_ongoing_flush) n_clr_ong++;
            if (set_ongoing_flush) n_set_ong++;
            if (incr_flush_set && flush_set == (SET_BITS+1)'(L2_SETS - 1)) begin
                last_adv_seen = 1; last_adv_cyc = cyc;
            end
            ev_run = (evict_valid && !evict_ready) ? ev_run + 1 : 0;

            s_rd_req = rd_req_valid; s_rd_set = rd_set; s_rd_way = rd_way;
            s_ev_valid = evict_valid; s_ev_ready = evict_ready;
            s_ev_set = evict_set; s_ev_way = evict_way;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive();
        rd_rsp_valid = 1'b0;
        if (s_rd_req) begin
            pend = 1; pend_cnt = $urandom_range(0, rsp_lat_max);
            pend_set = s_rd_set; pend_way = s_rd_way;
        end
        if (pend) begin
            if (pend_cnt == 0) begin
                rd_rsp_valid = 1'b1;
                rd_rsp_vld   = mem_vld[pend_set][pend_way];
                rd_rsp_dirty = mem_dirty[pend_set][pend_way];
                pend = 0;
            end else pend_cnt--;
        end else if (spur_en && $urandom_range(0, 5) == 0) begin
            rd_rsp_valid = 1'b1;
            rd_rsp_vld   = 1'($urandom);
            rd_rsp_dirty = 1'($urandom);
        end
        case (ready_mode)
            0:       evict_ready = 1'($urandom);
            2:       evict_ready = (ev_run >= 4);
            default: evict_ready = 1'b1;
        endcase
        flush_hold = hold_force ? hold_val : (hold_rand && $urandom_range(0, 3) == 0);
        if (req_rand) begin
            flush_req_valid = busy ? ($urandom_range(0, 3) == 0) : 1'b0;
            flush_req_inval = 1'($urandom);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic clr_stats();
        n_rd = 0; n_fire = 0; n_inv = 0; n_done = 0; n_clr_ong = 0; n_set_ong = 0;
        n_ev_high = 0; n_ev_m0 = 0; n_rd_hold = 0; first_rd_cyc = -1; done_cyc = 0;
        last_adv_cyc = 0; last_adv_seen = 0; last_fire = '0; rd_log.delete();
    endtask

    task automatic directed_mode();
        ready_mode = 1; hold_force = 0; hold_rand = 0; spur_en = 0; req_rand = 0;
        rsp_lat_max = 0; ret_en = 1; mshr_force_en = 0;
    endtask

    task automatic set_mem(input bit all_vld, input bit rnd);
        for (int s = 0; s < L2_SETS; s++)
            for (int w = 0; w < L2_WAYS; w++) begin
                mem_vld[s][w]   = rnd ? 1'($urandom) : all_vld;
                mem_dirty[s][w] = rnd ? 1'($urandom) : 1'b0;
            end
    endtask

    task automatic start_flush(input bit inval);
        int k = 0;
        while (busy && k < 500) begin cycle(); k++; end
        chk("idle_before_start", 32'(busy), 32'd0);
        flush_req_valid = 1'b1;
        flush_req_inval = inval;
        cycle();
        flush_req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (n_done == 0 && k < budget) begin cycle(); k++; end
        chk("done_seen", 32'(n_done != 0), 32'd1);
        cycle();
    endtask

    initial begin
        set_mem(0, 0);
        clr_stats();
        ev_run = 0;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();

        // T1: all clean, 4 lookups in walk order, no evictions
        directed_mode(); clr_stats(); set_mem(1, 0);
        start_flush(0); wait_done(200);
        chk("t1_rd_count", n_rd, 4);
        chk("t1_fire_count", n_fire, 0);
        chk("t1_done_count", n_done, 1);
        for (int i = 0; i < 4; i++)
            if (i < rd_log.size()) chk("t1_rd_order", 32'(rd_log[i]), 32'((i / 2) * 2 + (i % 2)));

        // T2: only (1,0) dirty, no invalidate
        directed_mode(); clr_stats(); set_mem(1, 0); mem_dirty[1][0] = 1'b1;
        start_flush(0); wait_done(200);
        chk("t2_fire_count", n_fire, 1);
        chk("t2_fire_addr", 32'(last_fire), 32'b10);
        chk("t2_inv_count", n_inv, 0);

        // T3: all valid, invalidate, none dirty
        directed_mode(); clr_stats(); set_mem(1, 0);
        start_flush(1); wait_done(200);
        chk("t3_inv_count", n_inv, 4);
        chk("t3_clr_ongoing_once", n_clr_ong, 1);
        chk("t3_fire_count", n_fire, 0);

        // T4: dirty (0,1) while MSHRs are exhausted, slow eviction ready
        directed_mode(); clr_stats(); set_mem(1, 0); mem_dirty[0][1] = 1'b1;
        ready_mode = 2; mshr_force_en = 1; mshr_force = '0;
        start_flush(0);
        repeat (12) cycle();
        chk("t4_no_fire_yet", n_fire, 0);
        mshr_force = MSHR_BP1'(N_MSHR);
        cycle();
        mshr_force_en = 0;
        wait_done(200);
        chk("t4_evict_while_no_mshr", n_ev_m0, 0);
        chk("t4_fire_count", n_fire, 1);
        chk("t4_fire_addr", 32'(last_fire), 32'b01);
        chk("t4_valid_cycles", n_ev_high, 5);

        // T5: hold asserted at walk start
        directed_mode(); clr_stats(); set_mem(1, 0);
        hold_force = 1; hold_val = 1;
        start_flush(0);
        repeat (5) cycle();
        hold_val = 0;
        begin
            int rel_cyc = cyc + 1;
            wait_done(200);
            chk("t5_rd_under_hold", n_rd_hold, 0);
            chk("t5_first_rd_after_release", 32'(first_rd_cyc >= rel_cyc), 32'd1);
            chk("t5_rd_count", n_rd, 4);
        end

        // T6: drain waits for the MSHR pool to refill
        directed_mode(); clr_stats(); set_mem(0, 0);
        mshr_force_en = 1; mshr_force = MSHR_BP1'(N_MSHR - 1);
        start_flush(0);
        begin
            int k = 0;
            while (!last_adv_seen && k < 200) begin cycle(); k++; end
        end
        chk("t6_last_adv_seen", 32'(last_adv_seen), 32'd1);
        repeat (4) cycle();
        chk("t6_no_early_done", n_done, 0);
        mshr_force = MSHR_BP1'(N_MSHR);
        wait_done(50);
        mshr_force_en = 0;
        chk("t6_drain_wait", 32'(done_cyc - last_adv_cyc >= 5), 32'd1);

        // T7: reset in the middle of a walk
        directed_mode(); clr_stats(); set_mem(1, 0); mem_dirty[0][1] = 1'b1; mem_dirty[1][1] = 1'b1;
        ready_mode = 0;
        start_flush(1);
        repeat (6) cycle();
        #2 rst = 1'b1; flush_req_valid = 1'b0;
        cycle();
        cycle();
        rst = 1'b0; pend = 0; rd_rsp_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("t7_ready_after_reset", 32'(flush_req_ready), 32'd1);
        chk("t7_no_done", n_done, 0);
        cycle();
        clr_stats(); start_flush(0); wait_done(400);
        chk("t7_recovery_done", n_done, 1);

        // T8: extra requests during a walk are dropped
        directed_mode(); clr_stats(); set_mem(1, 0); req_rand = 1;
        start_flush(0); wait_done(200);
        req_rand = 0; flush_req_valid = 1'b0;
        chk("t8_accept_once", n_set_ong, 1);
        chk("t8_done_once", n_done, 1);

        // Randomized flushes
        for (int n = 0; n < 40; n++) begin
            directed_mode(); clr_stats(); set_mem(0, 1);
            ready_mode = 0; hold_rand = 1; spur_en = 1; req_rand = 1; rsp_lat_max = 2;
            start_flush(1'($urandom));
            wait_done(600);
            req_rand = 0; flush_req_valid = 1'b0;
            chk("rnd_done_once", n_done, 1);
        end

        repeat (4) cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule : tb_l2_flush_seq
`default_nettype wire
